// File: rtl/ysyx_22050058_ifu_resp.sv
// Instruction-fetch responder: turns the PC register's pc/ce into a single
// outstanding valid/ready read, selects the 32-bit word from the returned
// doubleword and presents it to the IF/ID boundary. Holds the PC through
// stallreq_if while a fetch is in flight and drops wrong-path responses
// after a jump.
//
// Handshake: a request transfers on a rising edge where mem_req_valid and
// mem_req_ready are both 1. Once mem_req_valid is raised, it and
// mem_req_addr stay stable until that transfer; a request is never
// withdrawn. mem_resp_valid is a one-cycle pulse with no back-pressure,
// with at most one response per accepted request, returned in order.
module ysyx_22050058_ifu_resp #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc,
    input  logic              ce,
    input  logic              isjump,
    input  logic [5:0]        stall,
    output logic              stallreq_if,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_req_addr,
    input  logic              mem_resp_valid,
    input  logic [DATA_W-1:0] mem_resp_data,
    output logic [31:0]       inst,
    output logic [ADDR_W-1:0] inst_pc,
    output logic              inst_valid,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,  // nothing outstanding
        S_REQ  = 2'd1,  // request presented, not yet accepted
        S_WAIT = 2'd2,  // request accepted, awaiting response
        S_HOLD = 2'd3   // response parked in the skid buffer while decode stalls
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [ADDR_W-1:0] r_req_pc;
    logic              r_drop;
    logic [31:0]       r_skid_inst;
    logic [ADDR_W-1:0] r_skid_pc;

    logic              w_dec_stall;
    logic              w_issue;
    logic              w_resp_take;
    logic              w_load_direct;
    logic              w_load_skid;
    logic              w_release;
    logic [31:0]       w_resp_word;
    logic              w_unused;

    // Only the decode-stall bit of the controller vector matters here.
    assign w_dec_stall = stall[1];
    assign w_unused    = ^{stall[5:2], stall[0]};

    // A fetch is issued from IDLE whenever the PC register presents one,
    // unless a redirect is replacing the address this very cycle.
    assign w_issue = (r_state == S_IDLE) & ce & ~isjump;

    // A response is kept only if it is for the right path and no redirect
    // coincides with it; otherwise it is silently dropped.
    assign w_resp_take   = (r_state == S_WAIT) & mem_resp_valid & ~r_drop & ~isjump;
    assign w_load_direct = w_resp_take & ~w_dec_stall;
    assign w_load_skid   = w_resp_take & w_dec_stall;
    assign w_release     = (r_state == S_HOLD) & ~w_dec_stall & ~isjump;

    // The memory returns an aligned doubleword; bit 2 of the fetch address
    // picks which half holds the instruction.
    assign w_resp_word = r_req_pc[2] ? mem_resp_data[63:32] : mem_resp_data[31:0];

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_issue) begin
                    w_state_nxt = mem_req_ready ? S_WAIT : S_REQ;
                end
            end
            S_REQ: begin
                // A redirect here does not cancel the request; it only
                // marks the eventual response for discard.
                if (mem_req_ready) begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (mem_resp_valid) begin
                    w_state_nxt = w_load_skid ? S_HOLD : S_IDLE;
                end
            end
            S_HOLD: begin
                if (isjump || !w_dec_stall) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Output logic: memory request, PC hold request and state visibility.
    always_comb begin
        mem_req_valid = 1'b0;
        mem_req_addr  = r_req_pc;
        stallreq_if   = 1'b0;
        dbg_state     = r_state;
        case (r_state)
            S_IDLE: begin
                mem_req_valid = ce & ~isjump;
                mem_req_addr  = pc;
                stallreq_if   = ce;
            end
            S_REQ: begin
                mem_req_valid = 1'b1;
                mem_req_addr  = r_req_pc;
                stallreq_if   = 1'b1;
            end
            S_WAIT: begin
                // The PC may advance in the cycle the good response arrives,
                // so the next fetch can issue right after the output loads.
                stallreq_if = ~(mem_resp_valid & ~r_drop & ~w_dec_stall);
            end
            S_HOLD: begin
                stallreq_if = 1'b1;
            end
            default: begin
                stallreq_if = 1'b0;
            end
        endcase
        // A redirect lets the PC register load the jump target immediately.
        if (isjump) begin
            stallreq_if = 1'b0;
        end
    end

    // Outstanding-fetch address and the wrong-path discard flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_req_pc <= '0;
            r_drop   <= 1'b0;
        end else begin
            if (w_issue) begin
                r_req_pc <= pc;
                r_drop   <= 1'b0;
            end else if (isjump && (r_state == S_REQ || r_state == S_WAIT)) begin
                r_drop <= 1'b1;
            end
        end
    end

    // One-entry skid buffer for a response that lands while decode stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_skid_inst <= '0;
            r_skid_pc   <= '0;
        end else if (w_load_skid) begin
            r_skid_inst <= w_resp_word;
            r_skid_pc   <= r_req_pc;
        end
    end

    // IF/ID output register: load, bubble, hold under stall, flush on jump.
    always_ff @(posedge clk) begin
        if (rst) begin
            inst       <= '0;
            inst_pc    <= '0;
            inst_valid <= 1'b0;
        end else if (isjump) begin
            inst_valid <= 1'b0;
        end else if (w_load_direct) begin
            inst       <= w_resp_word;
            inst_pc    <= r_req_pc;
            inst_valid <= 1'b1;
        end else if (w_release) begin
            inst       <= r_skid_inst;
            inst_pc    <= r_skid_pc;
            inst_valid <= 1'b1;
        end else if (!w_dec_stall) begin
            inst_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ysyx_22050058_ifu_resp.sv
// Bench for ysyx_22050058_ifu_resp: scripted cycle-by-cycle scenarios acting
// as PC register, controller and instruction memory, with a scoreboard of
// expected {inst_pc, inst} pairs checked whenever the output register loads.
module tb_ysyx_22050058_ifu_resp;

  logic        clk;
  logic        rst;
  logic [63:0] pc;
  logic        ce;
  logic        isjump;
  logic [5:0]  stall;
  logic        stallreq_if;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [63:0] mem_req_addr;
  logic        mem_resp_valid;
  logic [63:0] mem_resp_data;
  logic [31:0] inst;
  logic [63:0] inst_pc;
  logic        inst_valid;
  logic [1:0]  dbg_state;

  int n_vec;
  int n_err;

  logic [95:0] exp_q[$];

  ysyx_22050058_ifu_resp #(.ADDR_W(64), .DATA_W(64)) dut (
    .clk            (clk),
    .rst            (rst),
    .pc             (pc),
    .ce             (ce),
    .isjump         (isjump),
    .stall          (stall),
    .stallreq_if    (stallreq_if),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_addr   (mem_req_addr),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_data  (mem_resp_data),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .inst_valid     (inst_valid),
    .dbg_state      (dbg_state)
  );

  // Clock and watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Scoreboard: the output register loads on an edge with no reset, no
  // jump and decode not stalled, leaving inst_valid = 1.
  logic        m_s1, m_j, m_r;
  logic [95:0] m_exp;
  always @(posedge clk) begin
    m_s1 = stall[1];
    m_j  = isjump;
    m_r  = rst;
    #1;
    if (!m_r && !m_j && !m_s1 && inst_valid === 1'b1) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL sb_extra got pc=%h inst=%h, nothing expected", inst_pc, inst);
      end else begin
        m_exp = exp_q.pop_front();
        if ({inst_pc, inst} !== m_exp) begin
          n_err++;
          $display("FAIL sb_inst got pc=%h inst=%h exp pc=%h inst=%h",
                   inst_pc, inst, m_exp[95:32], m_exp[31:0]);
        end
      end
    end
  end

  // Driver tasks: drive at posedge+2, check at posedge+3.
  task automatic go();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  function automatic logic [31:0] sel_word(input logic [63:0] a, input logic [63:0] d);
    return a[2] ? d[63:32] : d[31:0];
  endfunction

  // Ready memory, 1-cycle read; ends at the drive point after the response
  // with ce = 0 already driven.
  task automatic fetch_simple(input logic [63:0] a, input logic [63:0] d);
    ce = 1'b1; pc = a; mem_req_ready = 1'b1; mem_resp_valid = 1'b0;
    go();
    mem_resp_valid = 1'b1; mem_resp_data = d;
    exp_q.push_back({a, sel_word(a, d)});
    go();
    mem_resp_valid = 1'b0; ce = 1'b0;
  endtask

  task automatic test_reset();
    go();
    go();
    rst = 1'b0;
    settle();
    n_vec++;
    if ({inst_valid, mem_req_valid, stallreq_if} !== 3'b000 || inst !== 32'd0 ||
        inst_pc !== 64'd0 || dbg_state !== 2'd0) begin
      n_err++;
      $display("FAIL reset_outputs got v=%b rv=%b sr=%b inst=%h pc=%h st=%0d exp all 0",
               inst_valid, mem_req_valid, stallreq_if, inst, inst_pc, dbg_state);
    end
    go();
  endtask

  task automatic test_basic();
    int hi_cnt;
    hi_cnt = 0;
    ce = 1'b1; pc = 64'h8000_0000; mem_req_ready = 1'b1; mem_resp_valid = 1'b0;
    settle();
    n_vec++;
    if (mem_req_valid !== 1'b1 || mem_req_addr !== 64'h8000_0000) begin
      n_err++;
      $display("FAIL basic_req got valid=%b addr=%h exp 1 80000000", mem_req_valid, mem_req_addr);
    end
    if (stallreq_if === 1'b1) hi_cnt++;
    go();
    mem_resp_valid = 1'b1; mem_resp_data = 64'h00100093_00000413;
    exp_q.push_back({64'h8000_0000, 32'h00000413});
    settle();
    if (stallreq_if === 1'b1) hi_cnt++;
    go();
    mem_resp_valid = 1'b0; ce = 1'b0;
    settle();
    if (stallreq_if === 1'b1) hi_cnt++;
    n_vec++;
    if (inst_valid !== 1'b1 || inst !== 32'h00000413 || inst_pc !== 64'h8000_0000) begin
      n_err++;
      $display("FAIL basic_out got v=%b inst=%h pc=%h exp 1 00000413 80000000", inst_valid, inst, inst_pc);
    end
    n_vec++;
    if (hi_cnt != 1) begin
      n_err++;
      $display("FAIL basic_stallreq_cycles got %0d exp 1", hi_cnt);
    end
    go();
    settle();
    n_vec++;
    if (inst_valid !== 1'b0) begin
      n_err++;
      $display("FAIL basic_bubble got inst_valid=%b exp 0", inst_valid);
    end
    go();
  endtask

  task automatic test_upper_word();
    fetch_simple(64'h8000_0004, 64'h00100093_00000413);
    settle();
    n_vec++;
    if (inst_valid !== 1'b1 || inst !== 32'h00100093 || inst_pc !== 64'h8000_0004) begin
      n_err++;
      $display("FAIL upper_word got v=%b inst=%h pc=%h exp 1 00100093 80000004", inst_valid, inst, inst_pc);
    end
    go();
  endtask

  task automatic test_ready_stall();
    int acc;
    acc = 0;
    ce = 1'b1; pc = 64'h8000_0008; mem_req_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) pc = 64'h0000_0000_0000_1234;
      settle();
      n_vec++;
      if (mem_req_valid !== 1'b1 || mem_req_addr !== 64'h8000_0008 || stallreq_if !== 1'b1) begin
        n_err++;
        $display("FAIL ready_stall_c%0d got valid=%b addr=%h sr=%b exp 1 80000008 1",
                 k, mem_req_valid, mem_req_addr, stallreq_if);
      end
      if (mem_req_valid === 1'b1 && mem_req_ready === 1'b1) acc++;
      go();
    end
    pc = 64'h8000_0008; mem_req_ready = 1'b1;
    settle();
    n_vec++;
    if (mem_req_valid !== 1'b1 || mem_req_addr !== 64'h8000_0008) begin
      n_err++;
      $display("FAIL ready_accept got valid=%b addr=%h exp 1 80000008", mem_req_valid, mem_req_addr);
    end
    if (mem_req_valid === 1'b1 && mem_req_ready === 1'b1) acc++;
    go();
    mem_resp_valid = 1'b1; mem_resp_data = 64'hcafef00d_0badc0de;
    exp_q.push_back({64'h8000_0008, 32'h0badc0de});
    settle();
    if (mem_req_valid === 1'b1 && mem_req_ready === 1'b1) acc++;
    go();
    mem_resp_valid = 1'b0; ce = 1'b0;
    settle();
    if (mem_req_valid === 1'b1 && mem_req_ready === 1'b1) acc++;
    n_vec++;
    if (acc != 1) begin
      n_err++;
      $display("FAIL ready_accept_count got %0d exp 1", acc);
    end
    go();
  endtask

  task automatic test_decode_stall();
    fetch_simple(64'h8000_0010, 64'h11111111_22222222);
    ce = 1'b1; pc = 64'h8000_0014; stall = 6'b000010;
    settle();
    n_vec++;
    if (mem_req_valid !== 1'b1 || stallreq_if !== 1'b1) begin
      n_err++;
      $display("FAIL dstall_issue got valid=%b sr=%b exp 1 1", mem_req_valid, stallreq_if);
    end
    go();
    mem_resp_valid = 1'b1; mem_resp_data = 64'h33333333_44444444;
    exp_q.push_back({64'h8000_0014, 32'h33333333});
    settle();
    n_vec++;
    if (stallreq_if !== 1'b1) begin
      n_err++;
      $display("FAIL dstall_resp_sr got %b exp 1", stallreq_if);
    end
    go();
    mem_resp_valid = 1'b0;
    settle();
    n_vec++;
    if (dbg_state !== 2'd3 || stallreq_if !== 1'b1 || inst_valid !== 1'b1 ||
        inst !== 32'h22222222 || inst_pc !== 64'h8000_0010 || mem_req_valid !== 1'b0) begin
      n_err++;
      $display("FAIL dstall_hold got st=%0d sr=%b v=%b inst=%h pc=%h rv=%b exp 3 1 1 22222222 80000010 0",
               dbg_state, stallreq_if, inst_valid, inst, inst_pc, mem_req_valid);
    end
    go();
    stall = 6'b0; ce = 1'b0;
    settle();
    n_vec++;
    if (stallreq_if !== 1'b1 || inst !== 32'h22222222) begin
      n_err++;
      $display("FAIL dstall_release_cycle got sr=%b inst=%h exp 1 22222222", stallreq_if, inst);
    end
    go();
    settle();
    n_vec++;
    if (inst_valid !== 1'b1 || inst !== 32'h33333333 || inst_pc !== 64'h8000_0014 || dbg_state !== 2'd0) begin
      n_err++;
      $display("FAIL dstall_released got v=%b inst=%h pc=%h st=%0d exp 1 33333333 80000014 0",
               inst_valid, inst, inst_pc, dbg_state);
    end
    go();
  endtask

  task automatic test_jump();
    fetch_simple(64'h8000_0020, 64'h55555555_66666666);
    // keep the previous instruction valid under stall, then redirect
    ce = 1'b1; pc = 64'h8000_0028; stall = 6'b000010;
    go();
    isjump = 1'b1; pc = 64'h8000_0100;
    settle();
    n_vec++;
    if (stallreq_if !== 1'b0 || inst_valid !== 1'b1 || mem_req_valid !== 1'b0) begin
      n_err++;
      $display("FAIL jump_cycle got sr=%b v=%b rv=%b exp 0 1 0", stallreq_if, inst_valid, mem_req_valid);
    end
    go();
    isjump = 1'b0; stall = 6'b0;
    settle();
    n_vec++;
    if (inst_valid !== 1'b0 || stallreq_if !== 1'b1 || mem_req_valid !== 1'b0 || dbg_state !== 2'd2) begin
      n_err++;
      $display("FAIL jump_after got v=%b sr=%b rv=%b st=%0d exp 0 1 0 2",
               inst_valid, stallreq_if, mem_req_valid, dbg_state);
    end
    go();
    mem_resp_valid = 1'b1; mem_resp_data = 64'hdeaddead_deaddead;
    settle();
    n_vec++;
    if (stallreq_if !== 1'b1) begin
      n_err++;
      $display("FAIL jump_drop_sr got %b exp 1", stallreq_if);
    end
    go();
    mem_resp_valid = 1'b0;
    settle();
    n_vec++;
    if (dbg_state !== 2'd0 || inst_valid !== 1'b0 || mem_req_valid !== 1'b1 || mem_req_addr !== 64'h8000_0100) begin
      n_err++;
      $display("FAIL jump_target_req got st=%0d v=%b rv=%b addr=%h exp 0 0 1 80000100",
               dbg_state, inst_valid, mem_req_valid, mem_req_addr);
    end
    go();
    mem_resp_valid = 1'b1; mem_resp_data = 64'h00000013_00000297;
    exp_q.push_back({64'h8000_0100, 32'h00000297});
    go();
    mem_resp_valid = 1'b0; ce = 1'b0;
    settle();
    n_vec++;
    if (inst_valid !== 1'b1 || inst !== 32'h00000297 || inst_pc !== 64'h8000_0100) begin
      n_err++;
      $display("FAIL jump_target_out got v=%b inst=%h pc=%h exp 1 00000297 80000100", inst_valid, inst, inst_pc);
    end
    go();
    // jump coinciding with the response in WAIT
    ce = 1'b1; pc = 64'h8000_0200;
    go();
    mem_resp_valid = 1'b1; mem_resp_data = 64'h01010101_02020202; isjump = 1'b1; pc = 64'h8000_0300;
    settle();
    n_vec++;
    if (stallreq_if !== 1'b0) begin
      n_err++;
      $display("FAIL jump_resp_sr got %b exp 0", stallreq_if);
    end
    go();
    mem_resp_valid = 1'b0; isjump = 1'b0; ce = 1'b0;
    settle();
    n_vec++;
    if (dbg_state !== 2'd0 || inst_valid !== 1'b0 || inst_pc !== 64'h8000_0100) begin
      n_err++;
      $display("FAIL jump_resp_drop got st=%0d v=%b pc=%h exp 0 0 80000100", dbg_state, inst_valid, inst_pc);
    end
    go();
    // jump while a response is parked in HOLD
    ce = 1'b1; pc = 64'h8000_0400; stall = 6'b000010;
    go();
    mem_resp_valid = 1'b1; mem_resp_data = 64'h03030303_04040404;
    go();
    mem_resp_valid = 1'b0; ce = 1'b0; isjump = 1'b1;
    settle();
    n_vec++;
    if (dbg_state !== 2'd3 || stallreq_if !== 1'b0) begin
      n_err++;
      $display("FAIL jump_hold got st=%0d sr=%b exp 3 0", dbg_state, stallreq_if);
    end
    go();
    isjump = 1'b0; stall = 6'b0;
    settle();
    n_vec++;
    if (dbg_state !== 2'd0 || inst_valid !== 1'b0) begin
      n_err++;
      $display("FAIL jump_hold_flush got st=%0d v=%b exp 0 0", dbg_state, inst_valid);
    end
    go();
  endtask

  task automatic test_reset_mid();
    fetch_simple(64'h8000_0030, 64'h77777777_88888888);
    ce = 1'b1; pc = 64'h8000_0038; stall = 6'b000010;
    go();
    rst = 1'b1;
    go();
    rst = 1'b0; stall = 6'b0; ce = 1'b0; pc = 64'd0;
    mem_resp_valid = 1'b1; mem_resp_data = 64'hbadbadba_dbadbadb;
    settle();
    n_vec++;
    if (inst !== 32'd0 || inst_pc !== 64'd0 || inst_valid !== 1'b0 || mem_req_valid !== 1'b0 ||
        mem_req_addr !== 64'd0 || stallreq_if !== 1'b0 || dbg_state !== 2'd0) begin
      n_err++;
      $display("FAIL rst_mid_outputs got inst=%h pc=%h v=%b rv=%b addr=%h sr=%b st=%0d exp all 0",
               inst, inst_pc, inst_valid, mem_req_valid, mem_req_addr, stallreq_if, dbg_state);
    end
    go();
    mem_resp_valid = 1'b0;
    settle();
    n_vec++;
    if (inst_valid !== 1'b0 || dbg_state !== 2'd0 || inst !== 32'd0) begin
      n_err++;
      $display("FAIL rst_late_resp got v=%b st=%0d inst=%h exp 0 0 0", inst_valid, dbg_state, inst);
    end
    fetch_simple(64'h8000_0040, 64'h99999999_aaaaaaaa);
    settle();
    n_vec++;
    if (inst_valid !== 1'b1 || inst !== 32'haaaaaaaa) begin
      n_err++;
      $display("FAIL rst_refetch got v=%b inst=%h exp 1 aaaaaaaa", inst_valid, inst);
    end
    go();
  endtask

  task automatic test_back_to_back();
    logic [63:0] a;
    logic [63:0] d;
    int w;
    int lat;
    for (int k = 0; k < 24; k++) begin
      a = 64'h8000_0000 + (64'($urandom_range(0, 255)) << 2);
      d = {$urandom, $urandom};
      w = $urandom_range(0, 2);
      lat = $urandom_range(1, 3);
      ce = 1'b1; pc = a;
      for (int c = 0; c < w; c++) begin
        mem_req_ready = 1'b0;
        settle();
        n_vec++;
        if (mem_req_valid !== 1'b1 || mem_req_addr !== a || stallreq_if !== 1'b1) begin
          n_err++;
          $display("FAIL b2b_req_hold k=%0d got valid=%b addr=%h sr=%b exp 1 %h 1",
                   k, mem_req_valid, mem_req_addr, stallreq_if, a);
        end
        go();
      end
      mem_req_ready = 1'b1;
      settle();
      n_vec++;
      if (mem_req_valid !== 1'b1 || mem_req_addr !== a) begin
        n_err++;
        $display("FAIL b2b_req k=%0d got valid=%b addr=%h exp 1 %h", k, mem_req_valid, mem_req_addr, a);
      end
      go();
      mem_req_ready = 1'($urandom_range(0, 1));
      for (int c = 1; c < lat; c++) begin
        settle();
        n_vec++;
        if (stallreq_if !== 1'b1 || mem_req_valid !== 1'b0) begin
          n_err++;
          $display("FAIL b2b_wait k=%0d got sr=%b rv=%b exp 1 0", k, stallreq_if, mem_req_valid);
        end
        go();
      end
      mem_resp_valid = 1'b1; mem_resp_data = d;
      exp_q.push_back({a, sel_word(a, d)});
      settle();
      n_vec++;
      if (stallreq_if !== 1'b0) begin
        n_err++;
        $display("FAIL b2b_resp_sr k=%0d got %b exp 0", k, stallreq_if);
      end
      go();
      mem_resp_valid = 1'b0;
    end
    ce = 1'b0;
    go();
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b1; ce = 1'b0; pc = 64'd0; isjump = 1'b0; stall = 6'b0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = 64'd0;
    test_reset();
    test_basic();
    test_upper_word();
    test_ready_stall();
    test_decode_stall();
    test_jump();
    test_reset_mid();
    test_back_to_back();
    go();
    settle();
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL sb_leftover got %0d pending exp 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ysyx_22050058_ifu_resp.md
# ysyx_22050058_ifu_resp

Instruction-fetch responder on the consumer side of the PC register's `pc`/`ce` output. It turns each presented fetch address into a valid/ready read on the instruction-memory bus and returns the selected 32-bit instruction to the IF/ID boundary. While a fetch is outstanding, it holds the PC register through the pipeline controller's stall request. It also discards wrong-path responses after a jump.

## Interface
- `ADDR_W`, 64: fetch address width; matches the instruction address bus.
- `DATA_W`, 64: memory read data width; fixed at 2 instruction words.
- `clk` in 1: single clock; all state updates on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `pc` in ADDR_W: fetch address from the PC register.
- `ce` in 1: fetch enable from the PC register; 0 means no fetch.
- `isjump` in 1: redirect from the execute block; the in-flight fetch is wrong-path.
- `stall` in 6: controller stall vector; only `stall[1]` (decode stalled) is used.
- `stallreq_if` out 1: request to the controller to hold the PC (`stall[0]`).
- `mem_req_valid` out 1: memory read request valid.
- `mem_req_ready` in 1: memory accepts the request.
- `mem_req_addr` out ADDR_W: read address, equal to `pc`, doubleword aligned by memory.
- `mem_resp_valid` in 1: read data valid for one cycle; at most one response per accepted request, in order.
- `mem_resp_data` in DATA_W: read data.
- `inst` out 32: instruction to decode.
- `inst_pc` out ADDR_W: address of `inst`.
- `inst_valid` out 1: `inst`/`inst_pc` are meaningful.

## Operation
- States:
  - IDLE: nothing outstanding.
  - REQ: request presented but not yet accepted.
  - WAIT: request accepted, awaiting response.
  - HOLD: response captured while decode is stalled.
- Internal registers:
  - `req_pc`: address of the outstanding fetch.
  - `drop`: discard the next response.
  - `skid_inst`, `skid_pc`: one-entry skid buffer.
- IDLE:
  - `mem_req_valid = ce & ~isjump`, `mem_req_addr = pc`.
  - On issue, latch `req_pc = pc`, `drop = 0`.
  - Go to WAIT if `mem_req_ready`, else REQ.
- REQ:
  - Hold `mem_req_valid = 1` and `mem_req_addr = req_pc` stable until `mem_req_ready`, then go to WAIT.
  - A request is never withdrawn.
- WAIT, on `mem_resp_valid`:
  - If `drop`, discard the response and go to IDLE.
  - Else if `~stall[1]`, load the output register and go to IDLE.
  - Else load the skid buffer and go to HOLD.
- HOLD: when `stall[1]` = 0, move the skid buffer to the output register and go to IDLE.
- Word select: `inst = req_pc[2] ? data[63:32] : data[31:0]`; `inst_pc = req_pc`.
- Output register:
  - When a new instruction is not loaded and `~stall[1]`, `inst_valid` goes to 0 (bubble).
  - Under `stall[1]`, `inst`, `inst_pc` and `inst_valid` all hold.
- `stallreq_if = ~isjump & ( (IDLE & ce) | REQ | (WAIT & ~(mem_resp_valid & ~drop & ~stall[1])) | HOLD )`. This is combinational.
- `isjump` = 1:
  - In REQ or WAIT: set `drop`; the transaction completes normally and its response is discarded.
  - In HOLD: discard the skid buffer and go to IDLE.
  - In any state: clear `inst_valid` next edge, overriding `stall[1]`.
  - `stallreq_if` is forced 0 that cycle so the PC register loads the jump address.

## Timing
- Reset (`rst` = 1 at an edge):
  - Next state IDLE; `drop`, `inst_valid`, `inst`, `inst_pc` and the skid buffer all 0.
  - `mem_req_valid` = 0 while `ce` = 0.
  - `rst` mid-transaction abandons it; the memory is reset by the same `rst`.
- Latency, with memory ready and 1-cycle read:
  - Request in cycle N; response in N+1.
  - `stallreq_if` drops in N+1; `inst_valid` = 1 and the PC advances at the N+2 edge.
  - Sustained throughput is 1 instruction per 2 cycles.
- A response that arrives while in IDLE or REQ is a protocol error; it is ignored.
- `isjump` coinciding with `mem_resp_valid` in WAIT: the response is discarded and the state goes to IDLE.
- `isjump` during REQ with `mem_req_ready` = 1 in the same cycle: go to WAIT with `drop` = 1.
- One outstanding request at most; no address wrap concerns (`pc` is supplied externally).

## Test plan
- Reset, then `ce` = 1, `pc` = 0x80000000, memory always ready, 1-cycle latency, data 0x00100093_00000413:
  - `inst` = 0x00000413, `inst_pc` = 0x80000000, `inst_valid` = 1 two cycles after the request.
  - `stallreq_if` high exactly 1 cycle.
- `pc` = 0x80000004 with the same data -> `inst` = 0x00100093 (upper word selected).
- `mem_req_ready` held 0 for 3 cycles -> `mem_req_valid` and `mem_req_addr` stable throughout; `stallreq_if` = 1 all 3 cycles; one request accepted.
- Response arrives while `stall[1]` = 1 for 2 cycles:
  - Output holds its old value; state HOLD; `stallreq_if` = 1.
  - Released value appears the cycle after `stall[1]` falls.
- `isjump` = 1 in WAIT with a 3-cycle memory:
  - `stallreq_if` = 0 that cycle; `inst_valid` = 0 next edge.
  - Old response discarded; next request issued to the jump target 0x80000100.
- `rst` asserted in WAIT -> all outputs 0 next cycle; a late response is ignored; a new fetch proceeds normally.
